register_slice_pipe: RTL and testbench

Parametrised chain of valid/ready register slices. It is the handshake-aware successor to the plain reset register: data advances only on completed transfers, backpressure is absorbed without bubbles, and the pipe can be flushed. It sits on any streaming datapath that needs timing closure across long routes. Typical placements are between an arbiter and a FIFO, or between two clock-aligned blocks.

---
 rtl/svlib_reg_pkg.sv | 18 +
 rtl/register_slice_pipe_slice.sv | 116 +++++++++++
 rtl/register_slice_pipe.sv | 76 +++++++
 tb/tb_register_slice_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svlib_reg_pkg.sv
// Shared types for the register slice family: slice FSM encoding and
// per-slice storage depth helper.
package svlib_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    localparam int SKID_ENTRIES = 2;
    localparam int FWD_ENTRIES  = 1;

    function automatic int slice_entries(input int reg_ready);
        return (reg_ready != 0) ? SKID_ENTRIES : FWD_ENTRIES;
    endfunction

endpackage

// File: rtl/register_slice_pipe_slice.sv
// One valid/ready register slice: skid (2 entries, registered s_ready) or forward
// (1 entry, combinational s_ready); 1 cycle latency, stalls upstream only when full.
module register_slice
    import svlib_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               REG_READY = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    if (REG_READY != 0) begin : g_skid
        slice_state_t     state;
        slice_state_t     state_nxt;
        logic             ready_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        // ready_q mirrors the state the slice is about to enter, so upstream never
        // sees a combinational path from m_ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= EMPTY;
                ready_q <= 1'b0;
            end else if (flush) begin
                state   <= EMPTY;
                ready_q <= 1'b1;
            end else begin
                state   <= state_nxt;
                ready_q <= (state_nxt != FULL);
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                EMPTY: if (in_xfer) state_nxt = BUSY;
                BUSY: begin
                    if (in_xfer && !out_xfer)      state_nxt = FULL;
                    else if (!in_xfer && out_xfer) state_nxt = EMPTY;
                end
                FULL:    if (out_xfer) state_nxt = BUSY;
                default: state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q <= RESET_VAL;
                skid_q <= RESET_VAL;
            end else if (flush) begin
                main_q <= RESET_VAL;
                skid_q <= RESET_VAL;
            end else begin
                case (state)
                    EMPTY: if (in_xfer) main_q <= s_data;
                    BUSY: begin
                        if (in_xfer && out_xfer) main_q <= s_data;
                        else if (in_xfer)        skid_q <= s_data;
                    end
                    FULL:    if (out_xfer) main_q <= skid_q;
                    default: main_q <= main_q;
                endcase
            end
        end

        always_comb begin
            s_ready   = ready_q && !flush;
            m_valid   = (state != EMPTY) && !flush;
            m_data    = main_q;
            occupancy = (state == FULL) ? 2'd2 : ((state == BUSY) ? 2'd1 : 2'd0);
        end
    end else begin : g_fwd
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= RESET_VAL;
            end else if (flush) begin
                valid_q <= 1'b0;
                data_q  <= RESET_VAL;
            end else if (in_xfer) begin
                valid_q <= 1'b1;
                data_q  <= s_data;
            end else if (out_xfer) begin
                valid_q <= 1'b0;
            end
        end

        always_comb begin
            s_ready   = (!valid_q || m_ready) && !flush;
            m_valid   = valid_q && !flush;
            m_data    = data_q;
            occupancy = {1'b0, valid_q};
        end
    end

endmodule

// File: rtl/register_slice_pipe.sv
// DEPTH cascaded valid/ready slices with flush and occupancy count; DEPTH cycles
// latency when empty, full throughput, upstream stalls only when every slice is full.
module register_slice_pipe
    import svlib_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter int               REG_READY = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [WIDTH-1:0]                            s_data,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [WIDTH-1:0]                            m_data,
    output logic [$clog2(DEPTH*(1+REG_READY)+1)-1:0]    count
);

    localparam int CW = $bits(count);

    // Each stage owns its own handshake nets so the ready chain is a set of
    // distinct signals rather than one self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             in_vld;
        logic             in_rdy;
        logic [WIDTH-1:0] in_dat;
        logic             out_vld;
        logic             out_rdy;
        logic [WIDTH-1:0] out_dat;
        logic [1:0]       occ;
        logic [CW-1:0]    acc;

        if (k == 0) begin : g_src
            assign in_vld = s_valid;
            assign in_dat = s_data;
            assign acc    = CW'(occ);
        end else begin : g_link
            assign in_vld = g_stage[k-1].out_vld;
            assign in_dat = g_stage[k-1].out_dat;
            assign acc    = g_stage[k-1].acc + CW'(occ);
        end

        if (k == DEPTH - 1) begin : g_sink
            assign out_rdy = m_ready;
        end else begin : g_next
            assign out_rdy = g_stage[k+1].in_rdy;
        end

        register_slice #(
            .WIDTH     (WIDTH),
            .REG_READY (REG_READY),
            .RESET_VAL (RESET_VAL)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .s_valid   (in_vld),
            .s_ready   (in_rdy),
            .s_data    (in_dat),
            .m_valid   (out_vld),
            .m_ready   (out_rdy),
            .m_data    (out_dat),
            .occupancy (occ)
        );
    end

    assign s_ready = g_stage[0].in_rdy;
    assign m_valid = g_stage[DEPTH-1].out_vld;
    assign m_data  = g_stage[DEPTH-1].out_dat;
    assign count   = g_stage[DEPTH-1].acc;

endmodule

// File: tb/tb_register_slice_pipe.sv
// Bench for register_slice_pipe: three configurations share one stimulus stream,
// each tracked by an in-order FIFO model of accepted beats.
module tb_register_slice_pipe;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic       m_ready;
    logic [7:0] s_data;

    logic       sr_s3, mv_s3, sr_s2, mv_s2, sr_f2, mv_f2;
    logic [7:0] md_s3, md_s2, md_f2;
    logic [2:0] c_s3, c_s2;
    logic [1:0] c_f2;

    logic [31:0] sr[3], mv[3], md[3], cnt[3];

    int total = 0;
    int bad   = 0;

    // model: one FIFO per instance, [0]=skid depth 3, [1]=skid depth 2, [2]=forward depth 2
    logic [7:0] mem[3][64];
    int         head[3] = '{0, 0, 0};
    int         tail[3] = '{0, 0, 0};
    int         cap[3]  = '{6, 4, 2};
    bit         is_skid[3] = '{1'b1, 1'b1, 1'b0};
    bit         pend_push[3];
    bit         pend_pop[3];
    bit         pend_flush;
    logic [7:0] pend_dat;

    typedef struct {
        logic        sv;
        logic [7:0]  d;
        logic        mr;
        logic        fl;
        logic [31:0] e_sr;
        logic [31:0] e_mv;
        logic        chk;
        logic [31:0] e_md;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    register_slice_pipe #(.WIDTH(8), .DEPTH(3), .REG_READY(1), .RESET_VAL(RV)) u_s3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(sr_s3),
        .s_data(s_data), .m_valid(mv_s3), .m_ready(m_ready), .m_data(md_s3), .count(c_s3));
    register_slice_pipe #(.WIDTH(8), .DEPTH(2), .REG_READY(1), .RESET_VAL(RV)) u_s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(sr_s2),
        .s_data(s_data), .m_valid(mv_s2), .m_ready(m_ready), .m_data(md_s2), .count(c_s2));
    register_slice_pipe #(.WIDTH(8), .DEPTH(2), .REG_READY(0), .RESET_VAL(RV)) u_f2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(sr_f2),
        .s_data(s_data), .m_valid(mv_f2), .m_ready(m_ready), .m_data(md_f2), .count(c_f2));

    assign sr[0]  = {31'd0, sr_s3};
    assign sr[1]  = {31'd0, sr_s2};
    assign sr[2]  = {31'd0, sr_f2};
    assign mv[0]  = {31'd0, mv_s3};
    assign mv[1]  = {31'd0, mv_s2};
    assign mv[2]  = {31'd0, mv_f2};
    assign md[0]  = {24'd0, md_s3};
    assign md[1]  = {24'd0, md_s2};
    assign md[2]  = {24'd0, md_f2};
    assign cnt[0] = {29'd0, c_s3};
    assign cnt[1] = {29'd0, c_s2};
    assign cnt[2] = {30'd0, c_f2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sampling half: record handshakes mid-cycle and check count/data against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            pend_flush = flush;
            for (int i = 0; i < 3; i++) begin
                pend_push[i] = 1'b0;
                pend_pop[i]  = 1'b0;
            end
            pend_dat = s_data;
            if (rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("count[%0d]", i), cnt[i], 32'(tail[i] - head[i]));
                    if (flush) begin
                        check($sformatf("flush s_ready[%0d]", i), sr[i], 32'd0);
                        check($sformatf("flush m_valid[%0d]", i), mv[i], 32'd0);
                    end
                    if (is_skid[i] && (tail[i] - head[i]) == cap[i])
                        check($sformatf("full s_ready[%0d]", i), sr[i], 32'd0);
                    if (mv[i][0] && m_ready) begin
                        if (tail[i] == head[i]) begin
                            check($sformatf("valid while empty[%0d]", i), mv[i], 32'd0);
                        end else begin
                            check($sformatf("order data[%0d]", i), md[i],
                                  32'(mem[i][head[i] % 64]));
                            pend_pop[i] = 1'b1;
                        end
                    end
                    if (s_valid && sr[i][0]) pend_push[i] = 1'b1;
                end
            end
        end
    end

    // Commit half: apply recorded transfers at the edge, or clear on reset/flush.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n || pend_flush) begin
                    head[i] = 0;
                    tail[i] = 0;
                end else begin
                    if (pend_push[i]) begin
                        mem[i][tail[i] % 64] = pend_dat;
                        tail[i]++;
                    end
                    if (pend_pop[i]) head[i]++;
                end
                pend_push[i] = 1'b0;
                pend_pop[i]  = 1'b0;
            end
            pend_flush = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int outs[3];
        int ins[3];

        // backpressure then flush on the depth-2 skid pipe (instance 1)
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 32'h5A, 32'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 32'h5A, 32'd1};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1, 32'h01, 32'd2};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1, 32'h01, 32'd3};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 32'h01, 32'd4};
        tbl[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 32'h01, 32'd4};
        tbl[6]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 32'h02, 32'd3};
        tbl[7]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'd1, 32'd1, 1'b1, 32'h03, 32'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd1, 32'd1, 1'b1, 32'h04, 32'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd1, 32'd1, 1'b1, 32'h05, 32'd1};
        tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, 32'h00, 32'd0};
        tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, 32'h00, 32'd1};
        tbl[12] = '{1'b1, 8'h33, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1, 32'h11, 32'd2};
        tbl[13] = '{1'b1, 8'h44, 1'b1, 1'b1, 32'd0, 32'd0, 1'b1, 32'h11, 32'd3};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 32'h5A, 32'd0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 32'h5A, 32'd0};

        // reset held with s_valid high
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst m_valid[%0d]", i), mv[i], 32'd0);
                check($sformatf("rst m_data[%0d]", i), md[i], 32'h5A);
                check($sformatf("rst count[%0d]", i), cnt[i], 32'd0);
                check($sformatf("rst s_ready[%0d]", i), sr[i], is_skid[i] ? 32'd0 : 32'd1);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("post-rst s_ready skid3", sr[0], 32'd0);
        check("post-rst s_ready skid2", sr[1], 32'd0);
        check("post-rst s_ready fwd", sr[2], 32'd1);
        @(posedge clk);
        #1;
        check("first-edge s_ready skid3", sr[0], 32'd1);
        check("first-edge s_ready skid2", sr[1], 32'd1);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            s_valid = tbl[r].sv; s_data = tbl[r].d; m_ready = tbl[r].mr; flush = tbl[r].fl;
            #1;
            check($sformatf("tbl%0d s_ready", r), sr[1], tbl[r].e_sr);
            check($sformatf("tbl%0d m_valid", r), mv[1], tbl[r].e_mv);
            check($sformatf("tbl%0d count", r), cnt[1], tbl[r].e_cnt);
            if (tbl[r].chk) check($sformatf("tbl%0d m_data", r), md[1], tbl[r].e_md);
        end

        // latency through the depth-3 skid pipe
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1; flush = 1'b0;
        #1 check("lat accept", sr[0], 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (mv[0][0]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("latency cycles", 32'(lat), 32'd3);
        check("latency data", md[0], 32'hA5);
        @(negedge clk);
        #1;
        check("lat drained valid", mv[0], 32'd0);
        check("lat drained count", cnt[0], 32'd0);

        // sustained throughput with m_ready held high
        for (int i = 0; i < 3; i++) begin outs[i] = 0; ins[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'(c); m_ready = 1'b1;
            #1;
            if (c >= 10) begin
                for (int i = 0; i < 3; i++) begin
                    if (mv[i][0]) outs[i]++;
                    if (sr[i][0]) ins[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("throughput out[%0d]", i), 32'(outs[i]), 32'd20);
            check($sformatf("throughput in[%0d]", i), 32'(ins[i]), 32'd20);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);

        // async reset between edges with two entries held
        s_valid = 1'b1; s_data = 8'hC1; m_ready = 1'b0;
        @(negedge clk);
        s_data = 8'hC2;
        @(negedge clk);
        s_valid = 1'b0;
        #1 check("pre-arst count skid2", cnt[1], 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("arst m_valid skid2", mv[1], 32'd0);
        check("arst count skid2", cnt[1], 32'd0);
        check("arst count fwd", cnt[2], 32'd0);
        s_valid = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("arst release s_ready skid2", sr[1], 32'd0);
        check("arst release count skid2", cnt[1], 32'd0);
        @(posedge clk);
        #1 check("arst restart s_ready skid2", sr[1], 32'd1);

        // random traffic with occasional flush, then sustained drain
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            s_valid = 1'($urandom % 2);
            s_data  = 8'($urandom);
            m_ready = (c < 200) ? 1'($urandom % 2) : 1'b1;
            flush   = (c < 200) && ($urandom % 50 == 0);
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1; flush = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drained model[%0d]", i), 32'(tail[i] - head[i]), 32'd0);
            check($sformatf("drained count[%0d]", i), cnt[i], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
